// File: rtl/serial_alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller: op codes, FSM states,
// slice select encoding and the op -> slice-control decode.
package serial_alu_pkg;

   localparam logic [2:0] OP_AND  = 3'd0;
   localparam logic [2:0] OP_OR   = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_NOR  = 3'd4;
   localparam logic [2:0] OP_NAND = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SEL_AND = 2'd0,
      SEL_OR  = 2'd1,
      SEL_SUM = 2'd2
   } sel_t;

   typedef struct packed {
      logic ainvert;
      logic binvert;
      sel_t sel;
      logic arith;
   } slice_ctrl_t;

   // Codes 6 and 7 fall through to the AND default.
   function automatic slice_ctrl_t decode_op(input logic [2:0] op);
      slice_ctrl_t c;
      c = '{ainvert: 1'b0, binvert: 1'b0, sel: SEL_AND, arith: 1'b0};
      case (op)
         OP_OR:   c.sel = SEL_OR;
         OP_ADD:  begin c.sel = SEL_SUM; c.arith = 1'b1; end
         OP_SUB:  begin c.sel = SEL_SUM; c.arith = 1'b1; c.binvert = 1'b1; end
         OP_NOR:  begin c.ainvert = 1'b1; c.binvert = 1'b1; end
         OP_NAND: begin c.ainvert = 1'b1; c.binvert = 1'b1; c.sel = SEL_OR; end
         default: ;
      endcase
      return c;
   endfunction

   // SUB is a + ~b + 1, so its carry chain starts at 1.
   function automatic logic init_carry(input logic [2:0] op);
      return (op == OP_SUB);
   endfunction

endpackage

// File: rtl/serial_alu_ctrl_if.sv
// Request/result bundle for serial_alu_ctrl.
// Optional port ovf exists only when SERIAL_ALU_OVF_EN is defined.
interface serial_alu_ctrl_if #(parameter int WIDTH = 8);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             z;
`ifdef SERIAL_ALU_OVF_EN
   logic             ovf;

   modport master (output start, op, a, b, input busy, done, result, cout, z, ovf);
   modport slave  (input start, op, a, b, output busy, done, result, cout, z, ovf);
`else
   modport master (output start, op, a, b, input busy, done, result, cout, z);
   modport slave  (input start, op, a, b, output busy, done, result, cout, z);
`endif
endinterface

// File: rtl/serial_alu_ctrl_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, then AND/OR/full-add.
import serial_alu_pkg::*;

module alu_slice (
   input  logic i_a,
   input  logic i_b,
   input  logic i_ainvert,
   input  logic i_binvert,
   input  logic i_carryin,
   input  sel_t i_sel,
   output logic o_result,
   output logic o_cout
);
   logic w_a;
   logic w_b;

   assign w_a = i_a ^ i_ainvert;
   assign w_b = i_b ^ i_binvert;

   // select the slice output; carry is always the full-adder carry
   always_comb begin
      o_result = 1'b0;
      o_cout   = (w_a & w_b) | (w_a & i_carryin) | (w_b & i_carryin);
      case (i_sel)
         SEL_AND: o_result = w_a & w_b;
         SEL_OR:  o_result = w_a | w_b;
         SEL_SUM: o_result = w_a ^ w_b ^ i_carryin;
         default: o_result = 1'b0;
      endcase
   end
endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: captures a/b/op on start, runs WIDTH cycles
// through one alu_slice (LSB first), then pulses done with result/cout/z.
// Define SERIAL_ALU_OVF_EN to add the signed-overflow flag ovf.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on acceptance
// RUN     | one bit per cycle through the slice, WIDTH cycles
// DONE    | done pulse for one cycle, back to IDLE
import serial_alu_pkg::*;

module serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_alu_ctrl_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           r_state;
   state_t           w_next;
   logic             w_load;
   logic             w_step;
   logic             w_last;
   logic             w_busy;
   logic             w_done;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [2:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic [WIDTH-2:0] r_shift;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_z;
`ifdef SERIAL_ALU_OVF_EN
   logic             r_ovf;
`endif

   slice_ctrl_t      w_ctrl;
   logic             w_bit;
   logic             w_cout;
   logic [WIDTH-1:0] w_shift_next;

   assign w_ctrl       = decode_op(r_op);
   assign w_last       = (r_cnt == CW'(WIDTH - 1));
   assign w_shift_next = {w_bit, r_shift};

   alu_slice u_slice (
      .i_a       (r_a[0]),
      .i_b       (r_b[0]),
      .i_ainvert (w_ctrl.ainvert),
      .i_binvert (w_ctrl.binvert),
      .i_carryin (r_carry),
      .i_sel     (w_ctrl.sel),
      .o_result  (w_bit),
      .o_cout    (w_cout)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // next state and control strobes
   always_comb begin
      w_next = r_state;
      w_load = 1'b0;
      w_step = 1'b0;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start) begin
               w_next = ST_RUN;
               w_load = 1'b1;
            end
         end
         ST_RUN: begin
            w_busy = 1'b1;
            w_step = 1'b1;
            if (w_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // operand capture, serial datapath and result/flag update on the last bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_shift  <= '0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_z      <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else if (w_load) begin
         r_a     <= bus.a;
         r_b     <= bus.b;
         r_op    <= bus.op;
         r_cnt   <= '0;
         r_carry <= init_carry(bus.op);
      end else if (w_step) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_shift <= w_shift_next[WIDTH-1:1];
         r_carry <= w_cout;
         r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
         if (w_last) begin
            r_result <= w_shift_next;
            r_cout   <= w_ctrl.arith & w_cout;
            r_z      <= (w_shift_next == '0);
`ifdef SERIAL_ALU_OVF_EN
            // r_carry still holds the carry into the MSB here
            r_ovf    <= w_ctrl.arith & (r_carry ^ w_cout);
`endif
         end
      end
   end

   assign bus.busy   = w_busy;
   assign bus.done   = w_done;
   assign bus.result = r_result;
   assign bus.cout   = r_cout;
   assign bus.z      = r_z;
`ifdef SERIAL_ALU_OVF_EN
   assign bus.ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Randomized self-checking bench for serial_alu_ctrl against an arithmetic
// reference model. Covers latency, busy width, ignored start/operand changes,
// back-to-back issue interval and reset abort.
module tb_serial_alu_ctrl;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_alu_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // reference: {ovf, cout, result} from plain arithmetic
   function automatic logic [WIDTH+1:0] ref_alu(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      int unsigned s;
      logic [WIDTH-1:0] res;
      logic co;
      logic ov;
      co = 1'b0;
      ov = 1'b0;
      case (op)
         3'd1: res = a | b;
         3'd2: begin
            s   = int'(a) + int'(b);
            res = s[WIDTH-1:0];
            co  = s[WIDTH];
            ov  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         3'd3: begin
            res = a - b;
            co  = (a >= b);
            ov  = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         3'd4: res = ~(a | b);
         3'd5: res = ~(a & b);
         default: res = a & b;
      endcase
      return {ov, co, res};
   endfunction

   task automatic check_flags(input string tag, input logic [WIDTH+1:0] exp);
      check({tag, ".result"}, 32'(bus.result), 32'(exp[WIDTH-1:0]));
      check({tag, ".cout"}, 32'(bus.cout), 32'(exp[WIDTH]));
      check({tag, ".z"}, 32'(bus.z), 32'(exp[WIDTH-1:0] == '0));
`ifdef SERIAL_ALU_OVF_EN
      check({tag, ".ovf"}, 32'(bus.ovf), 32'(exp[WIDTH+1]));
`endif
   endtask

   // Call just after a negedge with the DUT idle; start is accepted at the next posedge.
   task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit disturb);
      logic [WIDTH+1:0] exp;
      int busy_n;
      int done_n;
      int done_k;
      exp    = ref_alu(op, a, b);
      busy_n = 0;
      done_n = 0;
      done_k = 0;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      for (int k = 1; k <= WIDTH + 3; k++) begin
         @(negedge clk);
         if (bus.busy) busy_n++;
         if (bus.done) begin
            done_n++;
            done_k = k;
            check_flags("at_done", exp);
         end
         if (disturb && k <= WIDTH) begin
            bus.start = 1'($urandom);
            bus.op    = 3'($urandom);
            bus.a     = WIDTH'($urandom);
            bus.b     = WIDTH'($urandom);
         end else begin
            bus.start = 1'b0;
         end
      end
      check("busy_cycles", 32'(busy_n), 32'(WIDTH));
      check("done_pulses", 32'(done_n), 32'd1);
      check("done_latency", 32'(done_k), 32'(WIDTH + 1));
      check_flags("held", exp);
   endtask

   task automatic back_to_back();
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      int rise[$];
      logic prev;
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      prev = 1'b0;
      bus.start = 1'b1;
      bus.op    = 3'd2;
      bus.a     = a;
      bus.b     = b;
      for (int c = 1; c <= 3 * (WIDTH + 2) + 2; c++) begin
         @(negedge clk);
         if (bus.busy && !prev) rise.push_back(c);
         prev = bus.busy;
      end
      bus.start = 1'b0;
      check("b2b_launches", 32'(rise.size() >= 3), 32'd1);
      if (rise.size() >= 2) check("b2b_interval", 32'(rise[1] - rise[0]), 32'(WIDTH + 2));
      repeat (WIDTH + 3) @(negedge clk);
      check_flags("b2b_final", ref_alu(3'd2, a, b));
   endtask

   task automatic reset_abort();
      int done_n;
      done_n = 0;
      bus.start = 1'b1;
      bus.op    = 3'd2;
      bus.a     = 8'h33;
      bus.b     = 8'h11;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      check("abort_busy_before", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_result", 32'(bus.result), 32'd0);
      repeat (WIDTH + 2) begin
         @(negedge clk);
         if (bus.done) done_n++;
      end
      check("abort_no_done", 32'(done_n), 32'd0);
      rst_n = 1'b1;
      do_op(3'd2, 8'hFF, 8'h01, 1'b0);
      check("abort_fresh_result", 32'(bus.result), 32'h00);
      check("abort_fresh_cout", 32'(bus.cout), 32'd1);
      check("abort_fresh_z", 32'(bus.z), 32'd1);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_cout", 32'(bus.cout), 32'd0);
      check("rst_z", 32'(bus.z), 32'd0);
`ifdef SERIAL_ALU_OVF_EN
      check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
      rst_n = 1'b1;
      // first start immediately after reset release
      do_op(3'd2, 8'h7F, 8'h01, 1'b0);
      check("add7f01_result", 32'(bus.result), 32'h80);
      check("add7f01_cout", 32'(bus.cout), 32'd0);
      do_op(3'd3, 8'h05, 8'h05, 1'b0);
      check("sub_eq_z", 32'(bus.z), 32'd1);
      do_op(3'd3, 8'h03, 8'h05, 1'b0);
      check("sub_lt_result", 32'(bus.result), 32'hFE);
      do_op(3'd4, 8'h00, 8'h00, 1'b0);
      check("nor_result", 32'(bus.result), 32'hFF);
      do_op(3'd5, 8'hFF, 8'h0F, 1'b0);
      check("nand_result", 32'(bus.result), 32'hF0);
      do_op(3'd0, 8'hF0, 8'h0F, 1'b0);
      check("and_z", 32'(bus.z), 32'd1);
      do_op(3'd6, 8'hCC, 8'hAA, 1'b0);
      do_op(3'd7, 8'h3C, 8'hF5, 1'b0);
      // start pulses and operand changes during RUN must be ignored
      do_op(3'd2, 8'h01, 8'h01, 1'b1);
      check("ignore_start_result", 32'(bus.result), 32'h02);
      for (int i = 0; i < 40; i++) begin
         do_op(3'($urandom_range(0, 7)), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      end
      back_to_back();
      do_op(3'd1, 8'h5A, 8'h00, 1'b0);
      reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
